lfsr_serial_rx: RTL and testbench
=================================

Name: lfsr_serial_rx

Overview:
Downstream consumer of the LFSR block's serial stream (OUT/Valid, LSB first). It reassembles WIDTH-bit words and optionally compares each word against an expected value. It keeps saturating word and error counters, and aborts a partial word when the serial stream stalls mid-word. It sits between the LFSR generator and the test/status register logic.

Parameters:
WIDTH, 8, word length in bits; matches the LFSR register width.
GAP_MAX, 4, number of consecutive idle cycles mid-word that triggers a timeout abort (must be >= 1).
CNT_W, 8, width of word_count and err_count.

Ports:
clock  in  1  single clock domain, rising edge.
reset  in  1  asynchronous, active-low reset.
ser_valid  in  1  serial bit qualifier (driven by the LFSR block's Valid).
ser_data  in  1  serial bit, LSB first (driven by the LFSR block's OUT).
expected  in  WIDTH  reference word for comparison.
compare_en  in  1  enables comparison and mismatch accounting.
clear  in  1  synchronous clear of counters, sticky flag and any partial word.
par_data  out  WIDTH  last completed word; held until the next completion.
par_valid  out  1  one-cycle pulse per completed word.
match  out  1  comparison result; meaningful only while par_valid=1.
mismatch_sticky  out  1  set on any mismatch; cleared by clear or reset.
timeout_err  out  1  one-cycle pulse on a mid-word abort.
word_count  out  CNT_W  completed words, saturating at all-ones.
err_count  out  CNT_W  mismatches plus timeouts, saturating at all-ones.
busy  out  1  high while in RECV.

Behaviour:
- Reset (reset=0, async): every output is 0. State is IDLE, bit counter 0, gap counter 0, shift register 0.
- FSM states: IDLE and RECV.
  - IDLE -> RECV on the first sampled bit (ser_valid=1).
  - RECV -> IDLE on word completion without a new bit, on timeout, or on clear.
- Shift: on each sampled bit, shift right and insert ser_data at the MSB. After WIDTH bits, the first-received bit sits at bit 0.
- Completion: the WIDTH-th bit is sampled at edge E. From E onward:
  - par_data holds the new word.
  - par_valid=1 for exactly one cycle.
  - match = (word == expected), using expected and compare_en as sampled at E; match=1 when compare_en=0.
- Counters at E:
  - word_count increments.
  - If compare_en=1 and the word differs from expected: err_count increments and mismatch_sticky is set.
- Latency: 1 cycle from the last bit to par_valid.
- Back-to-back: a bit presented while par_valid=1 is accepted as bit 0 of the next word, so there is no dead cycle. 2*WIDTH contiguous bits yield two pulses WIDTH cycles apart.
- Gap timer:
  - Counts consecutive cycles in RECV with ser_valid=0 and resets on every sampled bit.
  - On the GAP_MAX-th consecutive idle edge: discard the partial word, return to IDLE, pulse timeout_err for one cycle, and increment err_count.
  - No timeout while in IDLE or when 0 bits are held.
  - par_data keeps its previous value on a timeout.
- clear=1 (synchronous) has priority over all activity except reset:
  - Counters, mismatch_sticky, bit counter and gap counter go to 0; state goes to IDLE.
  - Any bit sampled in that cycle is dropped; no par_valid or timeout_err is produced that cycle.
  - par_data is retained.
- Saturation: counters hold at 2^CNT_W-1. When a mismatch and a timeout would coincide (impossible by construction), increment err_count by at most 1 per cycle.
- Reset mid-word: the partial word is lost and all outputs return to 0 immediately.

Decomposition:
- Package lfsr_pkg:
  - rx_state_t enum {IDLE, RECV}.
  - DEFAULT_WIDTH=8 constant, shared with the LFSR generator.
- Sub-module sat_counter (parameter CNT_W; ports inc, clr, count), instantiated twice, for word_count and err_count.

Test Plan:
- Reset, then 8 contiguous bits 1,0,1,0,0,1,0,1 with expected=0xA5, compare_en=1 -> par_data=0xA5, par_valid one cycle after the 8th bit, match=1, word_count=1, err_count=0.
- Same bits with expected=0x5A -> match=0, mismatch_sticky=1, err_count=1. Repeat with compare_en=0 -> err_count stays 1.
- 16 contiguous bits encoding 0x01 then 0x80 -> two par_valid pulses 8 cycles apart with par_data 0x01 then 0x80, and busy stays 1 between them.
- 3 bits, then 4 idle cycles (GAP_MAX=4) -> timeout_err pulse after the 4th idle edge, busy=0, err_count+1, par_data unchanged. Next 8 bits of 0xC3 -> par_data=0xC3.
- CNT_W=2, 5 words -> word_count=3 (saturated). clear pulse -> word_count=0, err_count=0, mismatch_sticky=0.
- reset asserted after 5 bits -> all outputs 0 asynchronously. After release, 8 bits of 0x3C -> par_data=0x3C, word_count=1.

Source files
------------

// File: rtl/lfsr_serial_rx_pkg.sv
// Types and constants shared by the LFSR generator and its serial receiver.
package lfsr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/lfsr_serial_rx_sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/lfsr_serial_rx.sv
// Reassembles the LFSR serial stream (LSB first) into words, checks them
// against a reference and keeps word/error statistics.
module lfsr_serial_rx
  import lfsr_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int GAP_MAX = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ser_valid,
  input  logic             ser_data,
  input  logic [WIDTH-1:0] expected,
  input  logic             compare_en,
  input  logic             clear,
  output logic [WIDTH-1:0] par_data,
  output logic             par_valid,
  output logic             match,
  output logic             mismatch_sticky,
  output logic             timeout_err,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = $clog2(GAP_MAX + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);

  rx_state_t        state_reg, state_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] par_data_reg, par_data_next;
  logic             par_valid_reg, par_valid_next;
  logic             match_reg, match_next;
  logic             sticky_reg, sticky_next;
  logic             timeout_reg, timeout_next;

  logic [WIDTH-1:0] new_word;
  logic [WIDTH-1:0] diff_bits;
  logic             word_differs;
  logic             word_inc;
  logic             mismatch;
  logic             err_inc;

  assign new_word = {ser_data, shift_reg[WIDTH-1:1]};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_diff
      assign diff_bits[gi] = new_word[gi] ^ expected[gi];
    end
  endgenerate

  assign word_differs = |diff_bits;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      shift_reg     <= '0;
      par_data_reg  <= '0;
      par_valid_reg <= 1'b0;
      match_reg     <= 1'b0;
      sticky_reg    <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      shift_reg     <= shift_next;
      par_data_reg  <= par_data_next;
      par_valid_reg <= par_valid_next;
      match_reg     <= match_next;
      sticky_reg    <= sticky_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    shift_next     = shift_reg;
    par_data_next  = par_data_reg;
    par_valid_next = 1'b0;
    match_next     = 1'b0;
    sticky_next    = sticky_reg;
    timeout_next   = 1'b0;
    word_inc       = 1'b0;
    mismatch       = 1'b0;

    if (clear) begin
      state_next   = IDLE;
      bit_cnt_next = '0;
      gap_cnt_next = '0;
      sticky_next  = 1'b0;
    end else if (ser_valid) begin
      state_next   = RECV;
      gap_cnt_next = '0;
      shift_next   = new_word;
      if (bit_cnt_reg == LAST_BIT) begin
        bit_cnt_next   = '0;
        par_data_next  = new_word;
        par_valid_next = 1'b1;
        match_next     = !compare_en || !word_differs;
        mismatch       = compare_en && word_differs;
        word_inc       = 1'b1;
      end else begin
        bit_cnt_next = bit_cnt_reg + 1'b1;
      end
    end else if (state_reg == RECV) begin
      // Staying in RECV with nothing held only covers the completion cycle,
      // so a contiguous next word keeps busy asserted.
      if (bit_cnt_reg == '0) begin
        state_next = IDLE;
      end else if (gap_cnt_reg == GAP_LAST) begin
        state_next   = IDLE;
        bit_cnt_next = '0;
        gap_cnt_next = '0;
        timeout_next = 1'b1;
      end else begin
        gap_cnt_next = gap_cnt_reg + 1'b1;
      end
    end

    if (mismatch) begin
      sticky_next = 1'b1;
    end
  end

  assign err_inc = mismatch | timeout_next;

  sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (word_inc),
    .clr   (clear),
    .count (word_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (err_inc),
    .clr   (clear),
    .count (err_count)
  );

  assign par_data        = par_data_reg;
  assign par_valid       = par_valid_reg;
  assign match           = match_reg;
  assign mismatch_sticky = sticky_reg;
  assign timeout_err     = timeout_reg;
  assign busy            = (state_reg == RECV);

endmodule

// File: tb/tb_lfsr_serial_rx.sv
// Directed bench for lfsr_serial_rx with WIDTH=8, GAP_MAX=4, CNT_W=2.
module tb_lfsr_serial_rx;

  logic       clock;
  logic       reset;
  logic       ser_valid;
  logic       ser_data;
  logic [7:0] expected;
  logic       compare_en;
  logic       clear;
  logic [7:0] par_data;
  logic       par_valid;
  logic       match;
  logic       mismatch_sticky;
  logic       timeout_err;
  logic [1:0] word_count;
  logic [1:0] err_count;
  logic       busy;

  int vec_count = 0;
  int err_total = 0;

  lfsr_serial_rx #(.WIDTH(8), .GAP_MAX(4), .CNT_W(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .ser_valid       (ser_valid),
    .ser_data        (ser_data),
    .expected        (expected),
    .compare_en      (compare_en),
    .clear           (clear),
    .par_data        (par_data),
    .par_valid       (par_valid),
    .match           (match),
    .mismatch_sticky (mismatch_sticky),
    .timeout_err     (timeout_err),
    .word_count      (word_count),
    .err_count       (err_count),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_total++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Drives n bits LSB first on consecutive cycles, then drops ser_valid.
  // Returns at the negedge just after the last bit was sampled.
  task automatic drive_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ser_valid = 1'b1;
      ser_data  = bits[i];
    end
    @(negedge clock);
    ser_valid = 1'b0;
    ser_data  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".par_data"}, 32'(par_data), 32'h0);
    check({tag, ".par_valid"}, 32'(par_valid), 32'h0);
    check({tag, ".match"}, 32'(match), 32'h0);
    check({tag, ".sticky"}, 32'(mismatch_sticky), 32'h0);
    check({tag, ".timeout"}, 32'(timeout_err), 32'h0);
    check({tag, ".word_cnt"}, 32'(word_count), 32'h0);
    check({tag, ".err_cnt"}, 32'(err_count), 32'h0);
    check({tag, ".busy"}, 32'(busy), 32'h0);
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    expected   = 8'h00;
    compare_en = 1'b0;
    clear      = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;

    // Word 0xA5 sent as 1,0,1,0,0,1,0,1
    expected   = 8'hA5;
    compare_en = 1'b1;
    drive_bits(16'h00A5, 7);
    check("a5.pv_before_last", 32'(par_valid), 32'h0);
    drive_bits(16'h0001, 1);
    check("a5.par_valid", 32'(par_valid), 32'h1);
    check("a5.par_data", 32'(par_data), 32'hA5);
    check("a5.match", 32'(match), 32'h1);
    check("a5.word_cnt", 32'(word_count), 32'h1);
    check("a5.err_cnt", 32'(err_count), 32'h0);
    @(negedge clock);
    check("a5.pv_one_cycle", 32'(par_valid), 32'h0);
    check("a5.busy_after", 32'(busy), 32'h0);

    expected = 8'h5A;
    drive_bits(16'h00A5, 8);
    check("mis.match", 32'(match), 32'h0);
    check("mis.sticky", 32'(mismatch_sticky), 32'h1);
    check("mis.err_cnt", 32'(err_count), 32'h1);
    check("mis.word_cnt", 32'(word_count), 32'h2);

    compare_en = 1'b0;
    drive_bits(16'h00A5, 8);
    check("nocmp.match", 32'(match), 32'h1);
    check("nocmp.err_cnt", 32'(err_count), 32'h1);
    check("nocmp.word_cnt", 32'(word_count), 32'h3);

    pulse_clear();
    check("clr1.word_cnt", 32'(word_count), 32'h0);
    check("clr1.err_cnt", 32'(err_count), 32'h0);
    check("clr1.sticky", 32'(mismatch_sticky), 32'h0);
    check("clr1.par_data", 32'(par_data), 32'hA5);

    // Back-to-back 0x01 then 0x80
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (i > 0) begin
        check($sformatf("b2b.busy%0d", i), 32'(busy), 32'h1);
        check($sformatf("b2b.pv%0d", i), 32'(par_valid), (i == 8) ? 32'h1 : 32'h0);
      end
      if (i == 8) check("b2b.first", 32'(par_data), 32'h01);
      ser_valid = 1'b1;
      ser_data  = (i == 0 || i == 15);
    end
    @(negedge clock);
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    check("b2b.pv_second", 32'(par_valid), 32'h1);
    check("b2b.second", 32'(par_data), 32'h80);
    check("b2b.word_cnt", 32'(word_count), 32'h2);

    // 3 bits then a 4-cycle stall
    drive_bits(16'h0003, 3);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      check($sformatf("gap.no_to%0d", k), 32'(timeout_err), 32'h0);
      check($sformatf("gap.busy%0d", k), 32'(busy), 32'h1);
    end
    @(negedge clock);
    check("gap.timeout", 32'(timeout_err), 32'h1);
    check("gap.busy", 32'(busy), 32'h0);
    check("gap.err_cnt", 32'(err_count), 32'h1);
    check("gap.par_data", 32'(par_data), 32'h80);
    check("gap.par_valid", 32'(par_valid), 32'h0);
    @(negedge clock);
    check("gap.to_pulse", 32'(timeout_err), 32'h0);
    drive_bits(16'h00C3, 8);
    check("c3.par_data", 32'(par_data), 32'hC3);
    check("c3.word_cnt", 32'(word_count), 32'h3);

    // Saturation of word_count
    pulse_clear();
    for (int w = 1; w <= 5; w++) drive_bits(16'(w * 17), 8);
    check("sat.word_cnt", 32'(word_count), 32'h3);
    check("sat.par_data", 32'(par_data), 32'h55);

    compare_en = 1'b1;
    expected   = 8'h00;
    for (int w = 0; w < 4; w++) drive_bits(16'h0011, 8);
    check("sat.err_cnt", 32'(err_count), 32'h3);
    check("sat.sticky", 32'(mismatch_sticky), 32'h1);

    // Reset in the middle of a word
    drive_bits(16'h001F, 5);
    check("rst.busy_before", 32'(busy), 32'h1);
    #2 reset = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clock);
    reset = 1'b1;
    compare_en = 1'b0;
    drive_bits(16'h003C, 8);
    check("3c.par_data", 32'(par_data), 32'h3C);
    check("3c.word_cnt", 32'(word_count), 32'h1);
    check("3c.err_cnt", 32'(err_count), 32'h0);

    // Bits presented during clear are dropped
    @(negedge clock);
    clear     = 1'b1;
    ser_valid = 1'b1;
    ser_data  = 1'b1;
    @(negedge clock);
    clear     = 1'b0;
    ser_valid = 1'b0;
    check("clr2.busy", 32'(busy), 32'h0);
    check("clr2.word_cnt", 32'(word_count), 32'h0);
    check("clr2.par_data", 32'(par_data), 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_total);
    $finish;
  end

endmodule
